// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the ALUSystem hardwired control sequencer.
// The CtrlWord bit layout is defined by ctrlWord_t (MSB first) and the CW_* offsets.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC0   = 3'd3,
    S_EXEC1   = 3'd4,
    S_HALT    = 3'd5
  } ctrlState_t;

  localparam logic [3:0] OP_LDI = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_ST  = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_BRA = 4'd8;
  localparam logic [3:0] OP_BZ  = 4'd9;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [1:0] FS_DEC   = 2'b00;
  localparam logic [1:0] FS_INC   = 2'b01;
  localparam logic [1:0] FS_LOAD  = 2'b10;
  localparam logic [1:0] FS_CLEAR = 2'b11;

  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;

  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_MEM  = 2'b01;
  localparam logic [1:0] MUX_IMM  = 2'b10;
  localparam logic [1:0] MUX_ARFC = 2'b11;

  localparam logic [1:0] ARF_SEL_PC = 2'b00;
  localparam logic [1:0] ARF_SEL_AR = 2'b01;
  localparam logic [2:0] ARF_EN_PC  = 3'b011;
  localparam logic [2:0] ARF_EN_AR  = 3'b101;

  typedef struct packed {
    logic [1:0] rfOutASel;
    logic [1:0] rfOutBSel;
    logic [1:0] rfFunSel;
    logic [3:0] rfRegSel;
    logic [3:0] aluFunSel;
    logic [1:0] arfOutCSel;
    logic [1:0] arfOutDSel;
    logic [1:0] arfFunSel;
    logic [2:0] arfRegSel;
    logic       irLH;
    logic       irEnable;
    logic [1:0] irFunSel;
    logic       memWR;
    logic       memCS;
    logic [1:0] muxASel;
    logic [1:0] muxBSel;
    logic       muxCSel;
  } ctrlWord_t;

  // LSB offset of each field inside the 34-bit CtrlWord.
  localparam int CW_MUXC = 0;
  localparam int CW_MUXB = 1;
  localparam int CW_MUXA = 3;
  localparam int CW_MEMCS = 5;
  localparam int CW_MEMWR = 6;
  localparam int CW_IRFUN = 7;
  localparam int CW_IREN = 9;
  localparam int CW_IRLH = 10;
  localparam int CW_ARFREG = 11;
  localparam int CW_ARFFUN = 14;
  localparam int CW_ARFOUTD = 16;
  localparam int CW_ARFOUTC = 18;
  localparam int CW_ALUFUN = 20;
  localparam int CW_RFREG = 24;
  localparam int CW_RFFUN = 28;
  localparam int CW_RFOUTB = 30;
  localparam int CW_RFOUTA = 32;

  localparam ctrlWord_t CTRL_IDLE = '{
    rfOutASel: 2'b00, rfOutBSel: 2'b00, rfFunSel: 2'b00, rfRegSel: 4'b1111,
    aluFunSel: 4'b0000, arfOutCSel: 2'b00, arfOutDSel: 2'b00, arfFunSel: 2'b00,
    arfRegSel: 3'b111, irLH: 1'b0, irEnable: 1'b0, irFunSel: 2'b00,
    memWR: 1'b0, memCS: 1'b1, muxASel: 2'b00, muxBSel: 2'b00, muxCSel: 1'b0
  };

  // RF register enables are active-low, one bit per register, R0 in the MSB.
  function automatic logic [3:0] rfEnable(input logic [1:0] rd);
    return ~(4'b1000 >> rd);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, IR, flags) into the 34-bit datapath control word.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  ctrlState_t  State,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output ctrlWord_t   CtrlWord
);

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       unusedBits;

  assign op = IROut[15:12];
  assign rd = IROut[11:10];
  assign rs = IROut[9:8];
  // The immediate reaches the datapath through MuxA/MuxB; only Z steers control.
  assign unusedBits = ^{IROut[7:0], Flags[2:0]};

  always_comb begin
    CtrlWord = CTRL_IDLE;
    case (State)
      S_INIT: begin
        if (CLEAR_ON_RESET) begin
          CtrlWord.rfRegSel  = 4'b0000;
          CtrlWord.rfFunSel  = FS_CLEAR;
          CtrlWord.arfRegSel = 3'b000;
          CtrlWord.arfFunSel = FS_CLEAR;
        end
      end
      S_FETCH_L, S_FETCH_H: begin
        CtrlWord.arfOutDSel = ARF_SEL_PC;
        CtrlWord.memCS      = 1'b0;
        CtrlWord.irEnable   = 1'b1;
        CtrlWord.irLH       = (State == S_FETCH_H);
        CtrlWord.irFunSel   = FS_LOAD;
        CtrlWord.arfRegSel  = ARF_EN_PC;
        CtrlWord.arfFunSel  = FS_INC;
      end
      S_EXEC0: begin
        case (op)
          OP_LDI: begin
            CtrlWord.rfRegSel = rfEnable(rd);
            CtrlWord.rfFunSel = FS_LOAD;
            CtrlWord.muxASel  = MUX_IMM;
          end
          OP_LD, OP_ST: begin
            CtrlWord.arfRegSel = ARF_EN_AR;
            CtrlWord.arfFunSel = FS_LOAD;
            CtrlWord.muxBSel   = MUX_IMM;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            CtrlWord.rfOutASel = rd;
            CtrlWord.rfOutBSel = rs;
            CtrlWord.aluFunSel = (op == OP_ADD) ? ALU_ADD :
                                 (op == OP_SUB) ? ALU_SUB : ALU_AND;
            CtrlWord.muxASel   = MUX_ALU;
            CtrlWord.rfRegSel  = rfEnable(rd);
            CtrlWord.rfFunSel  = FS_LOAD;
          end
          OP_INC, OP_DEC: begin
            CtrlWord.rfRegSel = rfEnable(rd);
            CtrlWord.rfFunSel = (op == OP_INC) ? FS_INC : FS_DEC;
          end
          OP_BRA, OP_BZ: begin
            if (op == OP_BRA || Flags[3]) begin
              CtrlWord.arfRegSel = ARF_EN_PC;
              CtrlWord.arfFunSel = FS_LOAD;
              CtrlWord.muxBSel   = MUX_IMM;
            end
          end
          default: ;
        endcase
      end
      S_EXEC1: begin
        // Second cycle of LD/ST: memory is addressed through ARF OutD = AR.
        if (op == OP_LD) begin
          CtrlWord.arfOutDSel = ARF_SEL_AR;
          CtrlWord.memCS      = 1'b0;
          CtrlWord.muxASel    = MUX_MEM;
          CtrlWord.rfRegSel   = rfEnable(rd);
          CtrlWord.rfFunSel   = FS_LOAD;
        end else if (op == OP_ST) begin
          CtrlWord.arfOutDSel = ARF_SEL_AR;
          CtrlWord.rfOutASel  = rs;
          CtrlWord.aluFunSel  = ALU_PASSA;
          CtrlWord.memCS      = 1'b0;
          CtrlWord.memWR      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the ALUSystem datapath.
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap ops 10-14 into HALT with a sticky Illegal flag.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int IR_W           = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [IR_W-1:0] IROut,
  input  logic [3:0]      Flags,
  output logic [33:0]     CtrlWord,
  output logic            Halted,
  output logic            Illegal,
  output logic [15:0]     RetireCnt,
  output ctrlState_t      DbgState
);

  ctrlState_t state;
  ctrlWord_t  word;
  logic [3:0] op;
  logic       trapOp;

  assign op       = IROut[15:12];
  assign DbgState = state;
  assign CtrlWord = word;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegalQ;
  assign trapOp  = (op >= 4'd10) && (op <= 4'd14);
  assign Illegal = illegalQ;
`else
  assign trapOp  = 1'b0;
  assign Illegal = 1'b0;
`endif

  ctrl_decode #(.CLEAR_ON_RESET(CLEAR_ON_RESET)) uDecode (
    .State    (state),
    .IROut    (IROut[15:0]),
    .Flags    (Flags),
    .CtrlWord (word)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= S_INIT;
      RetireCnt <= 16'd0;
      Halted    <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegalQ  <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT:    state <= S_FETCH_L;
        S_FETCH_L: state <= S_FETCH_H;
        S_FETCH_H: state <= S_EXEC0;
        S_EXEC0: begin
          if (op == OP_HLT) begin
            state     <= S_HALT;
            Halted    <= 1'b1;
            RetireCnt <= RetireCnt + 16'd1;
          end else if (op == OP_LD || op == OP_ST) begin
            state <= S_EXEC1;
          end else if (trapOp) begin
            // Trapped opcodes never retire.
            state  <= S_HALT;
            Halted <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegalQ <= 1'b1;
`endif
          end else begin
            state     <= S_FETCH_L;
            RetireCnt <= RetireCnt + 16'd1;
          end
        end
        S_EXEC1: begin
          state     <= S_FETCH_L;
          RetireCnt <= RetireCnt + 16'd1;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
